// File: rtl/dcache_access_ctrl_pkg.sv
// dcache_access_ctrl_pkg
// Shared definitions for the MEM-stage data-cache access controller:
// default data/address width and the access FSM state encoding.
package dcache_access_ctrl_pkg;

    localparam int data_size = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } dc_state_t;

endpackage

// File: rtl/dcache_access_ctrl_fwd.sv
// store_fwd_detect
// Combinational WB->MEM store-data hazard detection. A store in MEM whose
// data register is being written back this cycle must take the WB value.
// Register x0 is hard-wired to zero and never forwards.
// Ports:
//   mem_write  - store present in MEM
//   reg_write  - WB writeback enable
//   rd_addr    - WB destination register
//   rs2_addr   - MEM store-data source register
//   fwd        - forward WB write data into the store path
module store_fwd_detect (
    input  logic       mem_write,
    input  logic       reg_write,
    input  logic [4:0] rd_addr,
    input  logic [4:0] rs2_addr,
    output logic       fwd
);

    assign fwd = mem_write & reg_write & (rd_addr != 5'd0) & (rd_addr == rs2_addr);

endmodule

// File: rtl/dcache_access_ctrl.sv
// dcache_access_ctrl
// Sequences one D-cache access per MEM-stage load/store and stalls the
// pipeline until it completes.
//
//   state  | meaning
//   IDLE   | waiting for a MEM op; captures address/data on one
//   ACCESS | request outstanding, held until DC_stall drops
//   DONE   | one release cycle, no new access accepted
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   MemWrite_MEM/MemRead_MEM - store / load in MEM
//   rs2_addr_MEM             - store-data source register
//   RegWrite_WB, rd_addr_WB  - WB writeback enable / destination
//   Read_data_2_MEM          - MEM rs2 value
//   write_data               - WB writeback value
//   ALU_result_MEM           - effective address
//   DC_stall, DC_rdata       - cache busy / load data
//   D_in_sel                 - store-data select (1 = forwarded WB data)
//   DC_req, DC_we            - registered request / write enable
//   DC_addr, Dcache_in       - registered address / store data
//   pipe_stall               - hold IF..MEM
//   rdata_MEM                - registered load result
module dcache_access_ctrl
    import dcache_access_ctrl_pkg::*;
#(
    parameter int DATA_W = data_size
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemWrite_MEM,
    input  logic              MemRead_MEM,
    input  logic [4:0]        rs2_addr_MEM,
    input  logic              RegWrite_WB,
    input  logic [4:0]        rd_addr_WB,
    input  logic [DATA_W-1:0] Read_data_2_MEM,
    input  logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] ALU_result_MEM,
    input  logic              DC_stall,
    input  logic [DATA_W-1:0] DC_rdata,
    output logic              D_in_sel,
    output logic              DC_req,
    output logic              DC_we,
    output logic [DATA_W-1:0] DC_addr,
    output logic [DATA_W-1:0] Dcache_in,
    output logic              pipe_stall,
    output logic [DATA_W-1:0] rdata_MEM
);

    dc_state_t state, state_nxt;
    logic      fwd;
    logic      mem_op;

    assign mem_op = MemWrite_MEM | MemRead_MEM;

    store_fwd_detect u_fwd (
        .mem_write (MemWrite_MEM),
        .reg_write (RegWrite_WB),
        .rd_addr   (rd_addr_WB),
        .rs2_addr  (rs2_addr_MEM),
        .fwd       (fwd)
    );

    always_comb begin
        state_nxt  = state;
        pipe_stall = 1'b0;
        D_in_sel   = 1'b0;
        case (state)
            IDLE: begin
                D_in_sel = fwd;
                if (mem_op) begin
                    pipe_stall = 1'b1;
                    state_nxt  = ACCESS;
                end
            end
            ACCESS: begin
                pipe_stall = 1'b1;
                if (!DC_stall) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Outputs are quiet during reset whatever state the register holds.
        if (rst) begin
            pipe_stall = 1'b0;
            D_in_sel   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            DC_req    <= 1'b0;
            DC_we     <= 1'b0;
            DC_addr   <= '0;
            Dcache_in <= '0;
            rdata_MEM <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        DC_req    <= 1'b1;
                        // Load+store together is treated as a store.
                        DC_we     <= MemWrite_MEM;
                        DC_addr   <= ALU_result_MEM;
                        Dcache_in <= fwd ? write_data : Read_data_2_MEM;
                    end
                end
                ACCESS: begin
                    if (!DC_stall) begin
                        if (!DC_we) begin
                            rdata_MEM <= DC_rdata;
                        end
                        DC_req <= 1'b0;
                        DC_we  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_access_ctrl.sv
module tb_dcache_access_ctrl;

    logic        clk;
    logic        rst;
    logic        MemWrite_MEM, MemRead_MEM;
    logic [4:0]  rs2_addr_MEM;
    logic        RegWrite_WB;
    logic [4:0]  rd_addr_WB;
    logic [31:0] Read_data_2_MEM, write_data, ALU_result_MEM;
    logic        DC_stall;
    logic [31:0] DC_rdata;
    logic        D_in_sel, DC_req, DC_we, pipe_stall;
    logic [31:0] DC_addr, Dcache_in, rdata_MEM;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rdata;
        bit          is_load;
    } item_t;

    item_t       sb[$];
    item_t       head;
    logic [31:0] model_rdata;

    dcache_access_ctrl #(.DATA_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .MemWrite_MEM    (MemWrite_MEM),
        .MemRead_MEM     (MemRead_MEM),
        .rs2_addr_MEM    (rs2_addr_MEM),
        .RegWrite_WB     (RegWrite_WB),
        .rd_addr_WB      (rd_addr_WB),
        .Read_data_2_MEM (Read_data_2_MEM),
        .write_data      (write_data),
        .ALU_result_MEM  (ALU_result_MEM),
        .DC_stall        (DC_stall),
        .DC_rdata        (DC_rdata),
        .D_in_sel        (D_in_sel),
        .DC_req          (DC_req),
        .DC_we           (DC_we),
        .DC_addr         (DC_addr),
        .Dcache_in       (Dcache_in),
        .pipe_stall      (pipe_stall),
        .rdata_MEM       (rdata_MEM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_scramble();
        RegWrite_WB = 1'($urandom);
        rd_addr_WB  = 5'($urandom);
        write_data  = $urandom;
    endtask

    task automatic clear_mem();
        MemWrite_MEM    = 1'b0;
        MemRead_MEM     = 1'b0;
        rs2_addr_MEM    = 5'($urandom);
        Read_data_2_MEM = $urandom;
        ALU_result_MEM  = $urandom;
        DC_stall        = 1'($urandom);
        DC_rdata        = $urandom;
        wb_scramble();
    endtask

    task automatic idle_cycle();
        clear_mem();
        @(negedge clk);
        chk("idle_pipe_stall", {31'd0, pipe_stall}, 32'd0);
        chk("idle_dc_req", {31'd0, DC_req}, 32'd0);
        tick();
    endtask

    // Entered at posedge+1 of a cycle in which the DUT is IDLE; leaves at
    // posedge+1 of the following IDLE cycle.
    task automatic do_txn(input logic mw, input logic mr, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic rw, input logic [31:0] rd2,
                          input logic [31:0] wd, input logic [31:0] addr,
                          input logic [31:0] rdv, input int nstall, input bit abort);
        item_t it;
        bit    f;
        MemWrite_MEM    = mw;
        MemRead_MEM     = mr;
        rs2_addr_MEM    = rs2;
        rd_addr_WB      = rd;
        RegWrite_WB     = rw;
        Read_data_2_MEM = rd2;
        write_data      = wd;
        ALU_result_MEM  = addr;
        DC_stall        = 1'($urandom);
        DC_rdata        = $urandom;
        f          = mw && rw && (rd != 5'd0) && (rd == rs2);
        it.we      = mw;
        it.addr    = addr;
        it.data    = f ? wd : rd2;
        it.is_load = !mw;
        it.rdata   = rdv;
        sb.push_back(it);
        @(negedge clk);
        chk("idle_op_pipe_stall", {31'd0, pipe_stall}, 32'd1);
        chk("d_in_sel", {31'd0, D_in_sel}, {31'd0, f});
        for (int i = 0; i < nstall; i++) begin
            tick();
            wb_scramble();
            DC_stall = 1'b1;
            DC_rdata = $urandom;
            @(negedge clk);
            chk("stall_pipe_stall", {31'd0, pipe_stall}, 32'd1);
            chk("access_d_in_sel", {31'd0, D_in_sel}, 32'd0);
        end
        if (abort) begin
            tick();
            rst      = 1'b1;
            DC_stall = 1'b1;
            void'(sb.pop_back());
            @(negedge clk);
            chk("rst_pipe_stall", {31'd0, pipe_stall}, 32'd0);
            chk("rst_d_in_sel", {31'd0, D_in_sel}, 32'd0);
            tick();
            rst = 1'b0;
            clear_mem();
            @(negedge clk);
            chk("abort_dc_req", {31'd0, DC_req}, 32'd0);
            chk("abort_dc_we", {31'd0, DC_we}, 32'd0);
            chk("abort_dc_addr", DC_addr, 32'd0);
            chk("abort_dcache_in", Dcache_in, 32'd0);
            chk("abort_rdata", rdata_MEM, 32'd0);
            chk("abort_pipe_stall", {31'd0, pipe_stall}, 32'd0);
            tick();
            return;
        end
        tick();
        wb_scramble();
        DC_stall = 1'b0;
        DC_rdata = rdv;
        @(negedge clk);
        chk("complete_pipe_stall", {31'd0, pipe_stall}, 32'd1);
        // DONE: MEM op still presented, must not start a new access.
        tick();
        DC_stall = 1'($urandom);
        DC_rdata = $urandom;
        @(negedge clk);
        chk("done_pipe_stall", {31'd0, pipe_stall}, 32'd0);
        chk("done_dc_req", {31'd0, DC_req}, 32'd0);
        chk("done_dc_we", {31'd0, DC_we}, 32'd0);
        tick();
    endtask

    // Monitor/scoreboard: checks the request while it is outstanding and
    // retires it in the completing cycle; tracks the visible load result.
    always @(negedge clk) begin
        if (rst) begin
            model_rdata = 32'd0;
        end else begin
            chk("rdata_mem", rdata_MEM, model_rdata);
            if (DC_req) begin
                if (sb.size() == 0) begin
                    chk("spurious_dc_req", {31'd0, DC_req}, 32'd0);
                end else begin
                    chk("dc_we", {31'd0, DC_we}, {31'd0, sb[0].we});
                    chk("dc_addr", DC_addr, sb[0].addr);
                    chk("dcache_in", Dcache_in, sb[0].data);
                    if (!DC_stall) begin
                        head = sb.pop_front();
                        if (head.is_load) model_rdata = head.rdata;
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_mem();
        MemWrite_MEM = 1'b1;
        RegWrite_WB  = 1'b1;
        rd_addr_WB   = 5'd7;
        rs2_addr_MEM = 5'd7;
        repeat (2) begin
            tick();
            @(negedge clk);
            chk("reset_pipe_stall", {31'd0, pipe_stall}, 32'd0);
            chk("reset_d_in_sel", {31'd0, D_in_sel}, 32'd0);
        end
        tick();
        rst = 1'b0;
        clear_mem();
        @(negedge clk);
        chk("reset_dc_req", {31'd0, DC_req}, 32'd0);
        chk("reset_dc_we", {31'd0, DC_we}, 32'd0);
        chk("reset_dc_addr", DC_addr, 32'd0);
        chk("reset_dcache_in", Dcache_in, 32'd0);
        chk("reset_rdata", rdata_MEM, 32'd0);
        tick();

        // Plain store, forwarded store, x0 guard, stalled load.
        do_txn(1, 0, 5'd3, 5'd4, 1, 32'h1111_2222, 32'h5555_6666, 32'h100, 32'h0, 0, 0);
        do_txn(1, 0, 5'd5, 5'd5, 1, 32'h0BAD_0BAD, 32'hDEAD_BEEF, 32'h104, 32'h0, 0, 0);
        do_txn(1, 0, 5'd0, 5'd0, 1, 32'h1234_5678, 32'hFFFF_0000, 32'h108, 32'h0, 1, 0);
        do_txn(0, 1, 5'd5, 5'd5, 1, 32'h0, 32'h7777_7777, 32'h200, 32'hCAFE_0001, 3, 0);
        idle_cycle();
        // Store+load together acts as a store; rdata must hold.
        do_txn(1, 1, 5'd2, 5'd9, 1, 32'hA5A5_A5A5, 32'h0, 32'h300, 32'h0, 2, 0);
        // Back-to-back stores.
        do_txn(1, 0, 5'd6, 5'd1, 0, 32'h0000_0011, 32'h0, 32'h400, 32'h0, 0, 0);
        do_txn(1, 0, 5'd6, 5'd6, 1, 32'h0000_0022, 32'h0000_0033, 32'h404, 32'h0, 1, 0);
        // Reset mid-ACCESS.
        do_txn(0, 1, 5'd1, 5'd1, 0, 32'h0, 32'h0, 32'h500, 32'h1357_9BDF, 2, 1);
        idle_cycle();

        for (int n = 0; n < 200; n++) begin
            int op;
            op = $urandom_range(0, 2);
            do_txn(op != 1, op != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), $urandom, $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), ($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        idle_cycle();
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_access_ctrl.md
DCACHE_ACCESS_CTRL -- requirements
Module: dcache_access_ctrl

Interface
REQ-001 The block SHALL use parameter DATA_W, default `data_size (32), as the width of data and address paths.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 MemWrite_MEM, MemRead_MEM  input  1 each  store / load present in MEM stage.
REQ-005 rs2_addr_MEM  input  5  store-data source register of the MEM-stage instruction.
REQ-006 RegWrite_WB  input  1, rd_addr_WB  input  5  WB-stage writeback enable and destination.
REQ-007 Read_data_2_MEM, write_data  input  DATA_W each  MEM-stage rs2 value and WB-stage writeback value.
REQ-008 ALU_result_MEM  input  DATA_W  effective address.
REQ-009 DC_stall  input  1  D-cache busy; access completes in the cycle DC_req=1 and DC_stall=0.
REQ-010 DC_rdata  input  DATA_W  D-cache load data, valid in the completing cycle.
REQ-011 D_in_sel  output  1  store-data select: 0 = Read_data_2_MEM, 1 = write_data.
REQ-012 DC_req, DC_we  output  1 each  registered access request and write enable.
REQ-013 DC_addr, Dcache_in  output  DATA_W each  registered address and store data.
REQ-014 pipe_stall  output  1  hold IF..MEM stages.
REQ-015 rdata_MEM  output  DATA_W  registered load result.

Function
REQ-016 Forward condition fwd SHALL be MemWrite_MEM & RegWrite_WB & (rd_addr_WB != 0) & (rd_addr_WB == rs2_addr_MEM); D_in_sel SHALL equal fwd in IDLE and 0 in all other states.
REQ-017 FSM SHALL have states IDLE, ACCESS, DONE.
REQ-018 IDLE: on MemWrite_MEM | MemRead_MEM, pipe_stall=1 combinationally, capture DC_addr=ALU_result_MEM, DC_we=MemWrite_MEM, Dcache_in=(fwd ? write_data : Read_data_2_MEM), set DC_req=1, go ACCESS; otherwise pipe_stall=0, stay IDLE.
REQ-019 ACCESS: DC_req, DC_we, DC_addr, Dcache_in held constant, pipe_stall=1; when DC_stall=0, load rdata_MEM=DC_rdata if DC_we=0, clear DC_req and DC_we, go DONE; else stay.
REQ-020 DONE: pipe_stall=0 for exactly one cycle, no new access accepted, go IDLE unconditionally.
REQ-021 Minimum latency: 3 cycles from MEM op in IDLE to pipeline release (IDLE, ACCESS with DC_stall=0, DONE); each DC_stall=1 cycle in ACCESS adds one.
REQ-022 MemWrite_MEM and MemRead_MEM both 1 SHALL be treated as a store (DC_we=1).
REQ-023 rd_addr_WB = 0 SHALL never forward, even if rs2_addr_MEM = 0.
REQ-024 Store data SHALL be sampled only in IDLE; WB changes during ACCESS SHALL NOT alter Dcache_in.
REQ-025 rdata_MEM SHALL hold its value through stores and idle cycles until the next completing load.

Reset
REQ-026 rst=1 at a clock edge SHALL force state IDLE, DC_req=0, DC_we=0, DC_addr=0, Dcache_in=0, rdata_MEM=0, regardless of state, including mid-ACCESS.
REQ-027 While rst=1, pipe_stall=0 and D_in_sel=0.

Structure
REQ-028 The FSM state enum and DATA_W default SHALL be defined in the shared package (alongside `data_size), not locally.
REQ-029 Forward detection SHALL be one sub-module, store_fwd_detect (combinational, 5-bit compares, outputs fwd); the FSM and registers stay in the top.

Verification
REQ-030 Store, no hazard: MemWrite_MEM=1, Read_data_2_MEM=0x1111_2222, addr 0x100, DC_stall=0 -> DC_req=1, DC_we=1, Dcache_in=0x1111_2222, DC_addr=0x100 in cycle 2; pipe_stall 1,1,0.
REQ-031 Store with forward: rs2_addr_MEM=5, RegWrite_WB=1, rd_addr_WB=5, write_data=0xDEAD_BEEF -> D_in_sel=1 in IDLE, Dcache_in=0xDEAD_BEEF.
REQ-032 x0 guard: rs2_addr_MEM=0, rd_addr_WB=0, RegWrite_WB=1 -> D_in_sel=0, Dcache_in=Read_data_2_MEM.
REQ-033 Load with 3 stall cycles: MemRead_MEM=1, DC_stall=1 for 3 cycles then 0 with DC_rdata=0xCAFE_0001 -> pipe_stall high 5 cycles, rdata_MEM=0xCAFE_0001, DC_we=0 throughout.
REQ-034 Reset mid-ACCESS: rst=1 while DC_stall=1 -> next cycle DC_req=0, state IDLE, all registered outputs 0.
REQ-035 Back-to-back stores: two consecutive MEM stores -> second captured only in IDLE after DONE, no lost or duplicated DC_req.
